controle_varredura_servo: RTL and testbench

Position sequencer placed directly upstream of the PWM generator. It produces the 3-bit `largura` code that the PWM block consumes.
- Automatic mode: sweeps the code in a triangle (000→111→000…) and holds each position for a programmable dwell time.
- Manual mode: passes a user-selected code through.
- Also provides pause/resume, a cycle-complete pulse and debug state for the board displays.

---
 rtl/controle_varredura_servo_pkg.sv | 27 ++
 rtl/controle_varredura_servo_contador_m.sv | 29 ++
 rtl/controle_varredura_servo.sv | 112 +++++++++++
 tb/tb_controle_varredura_servo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_varredura_servo_pkg.sv
// Shared state encodings and the triangle-sweep step function for the servo sequencer.
`timescale 1ns/1ps
package controle_varredura_servo_pkg;

  localparam int LARGURA_ESTADO = 4;

  typedef enum logic [LARGURA_ESTADO-1:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    ESPERA  = 4'd2,
    AVANCA  = 4'd3,
    PAUSA   = 4'd4,
    MANUAL  = 4'd5
  } estado_t;

  // Returns {direcao, largura} after one sweep step; bounces at both ends, never wraps.
  function automatic logic [3:0] proxima_posicao(input logic dir, input logic [2:0] pos);
    logic [3:0] r;
    if (!dir) begin
      r = (pos == 3'b111) ? {1'b1, 3'b110} : {1'b0, pos + 3'd1};
    end else begin
      r = (pos == 3'b000) ? {1'b0, 3'b001} : {1'b1, pos - 3'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/controle_varredura_servo_contador_m.sv
// Modulo-M counter: zera clears, conta advances and wraps M-1 -> 0; fim flags the terminal count.
// Single-cycle update; holds its value whenever conta is low.
`timescale 1ns/1ps
module contador_m #(
  parameter int M = 50_000_000,
  parameter int N = 26
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  input  logic conta,
  output logic fim
);

  logic [N-1:0] q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      q <= (q == N'(M - 1)) ? '0 : q + 1'b1;
    end
  end

  assign fim = (q == N'(M - 1));

endmodule

// File: rtl/controle_varredura_servo.sv
// Servo position sequencer: triangle sweep of the 3-bit PWM code with programmable dwell, or manual pass-through.
// All outputs registered; a pause freezes the dwell timer and position in place.
`timescale 1ns/1ps
module controle_varredura_servo
  import controle_varredura_servo_pkg::*;
#(
  parameter int M_ESPERA = 50_000_000,
  parameter int N_ESPERA = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ligar,
  input  logic       pausar,
  input  logic       modo_manual,
  input  logic [2:0] posicao_manual,
  output logic [2:0] largura,
  output logic       direcao,
  output logic       passo,
  output logic       fim_ciclo,
  output logic [3:0] db_estado
);

  estado_t estado, estado_prox;
  logic    conta, zera, fim_espera;

  contador_m #(.M(M_ESPERA), .N(N_ESPERA)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .fim   (fim_espera)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= INICIAL;
    else        estado <= estado_prox;
  end

  // ligar=0 dominates every other input while sweeping.
  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL: estado_prox = ligar ? PREPARA : (modo_manual ? MANUAL : INICIAL);
      PREPARA: estado_prox = ligar ? ESPERA : INICIAL;
      ESPERA: begin
        if (!ligar)         estado_prox = INICIAL;
        else if (pausar)    estado_prox = PAUSA;
        else if (fim_espera) estado_prox = AVANCA;
        else                estado_prox = ESPERA;
      end
      PAUSA: begin
        if (!ligar)      estado_prox = INICIAL;
        else if (pausar) estado_prox = PAUSA;
        else             estado_prox = ESPERA;
      end
      AVANCA:  estado_prox = ligar ? ESPERA : INICIAL;
      MANUAL:  estado_prox = ligar ? PREPARA : (modo_manual ? MANUAL : INICIAL);
      default: estado_prox = INICIAL;
    endcase
  end

  always_comb begin
    conta     = 1'b0;
    zera      = 1'b0;
    db_estado = estado;
    case (estado)
      ESPERA:                   conta = ligar && !pausar;
      INICIAL, PREPARA, MANUAL: zera  = 1'b1;
      default: ;
    endcase
  end

  // The timer wraps to 0 on the same edge that enters AVANCA, so a new dwell starts clean.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      largura   <= 3'b000;
      direcao   <= 1'b0;
      passo     <= 1'b0;
      fim_ciclo <= 1'b0;
    end else begin
      passo     <= 1'b0;
      fim_ciclo <= 1'b0;
      case (estado)
        AVANCA: begin
          if (ligar) begin
            {direcao, largura} <= proxima_posicao(direcao, largura);
            passo              <= 1'b1;
            fim_ciclo          <= direcao && (largura == 3'b001);
          end else begin
            largura <= 3'b000;
            direcao <= 1'b0;
          end
        end
        ESPERA, PAUSA: begin
          if (!ligar) begin
            largura <= 3'b000;
            direcao <= 1'b0;
          end
        end
        MANUAL: begin
          largura <= (ligar || !modo_manual) ? 3'b000 : posicao_manual;
          direcao <= 1'b0;
        end
        default: begin
          largura <= 3'b000;
          direcao <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_varredura_servo.sv
// Directed bench for controle_varredura_servo with a 4-cycle dwell; samples on the falling edge.
`timescale 1ns/1ps
module tb_controle_varredura_servo;

  logic       clock = 1'b0;
  logic       reset;
  logic       ligar, pausar, modo_manual;
  logic [2:0] posicao_manual;
  logic [2:0] largura;
  logic       direcao, passo, fim_ciclo;
  logic [3:0] db_estado;

  int n_cmp = 0;
  int n_err = 0;

  controle_varredura_servo #(.M_ESPERA(4), .N_ESPERA(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .ligar          (ligar),
    .pausar         (pausar),
    .modo_manual    (modo_manual),
    .posicao_manual (posicao_manual),
    .largura        (largura),
    .direcao        (direcao),
    .passo          (passo),
    .fim_ciclo      (fim_ciclo),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  task automatic ciclo();
    @(negedge clock);
  endtask

  // Park in INICIAL, then raise ligar; the next ciclo() is sweep cycle k=1.
  task automatic iniciar_sweep();
    ligar = 1'b0; pausar = 1'b0; modo_manual = 1'b0;
    ciclo(); ciclo();
    ligar = 1'b1;
  endtask

  // Hand-derived sweep timeline for a 4-cycle dwell, k = edges since ligar was first sampled (k=1).
  // Packed as {db_estado, direcao, largura, passo, fim_ciclo}.
  function automatic logic [9:0] esperado(input int k);
    int s, idx;
    logic [3:0] db;
    logic [2:0] lar;
    logic dir, ps, fc;
    s   = (k >= 7) ? (k - 7) / 5 + 1 : 0;
    lar = 3'b000;
    dir = 1'b0;
    if (s > 0) begin
      idx = (s - 1) % 14;
      lar = (idx < 7) ? 3'(idx + 1) : 3'(13 - idx);
      dir = (idx >= 7);
    end
    if (k == 1)                        db = 4'd1;
    else if (k >= 6 && (k - 6) % 5 == 0) db = 4'd3;
    else                               db = 4'd2;
    ps = (k >= 7) && ((k - 7) % 5 == 0);
    fc = ps && (lar == 3'b000);
    return {db, dir, lar, ps, fc};
  endfunction

  task automatic test_reset();
    reset = 1'b0; ligar = 1'b1; pausar = 1'b0; modo_manual = 1'b0; posicao_manual = 3'b000;
    repeat (3) ciclo();
    n_cmp++;
    if ({db_estado, direcao, largura, passo, fim_ciclo} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_state: got %b required %b", {db_estado, direcao, largura, passo, fim_ciclo}, 10'd0);
    end
    reset = 1'b1;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd1) begin
      n_err++;
      $display("FAIL reset_release: db_estado got %0d required 1", db_estado);
    end
  endtask

  task automatic test_sweep();
    logic [9:0] obs, exp_v;
    int n_passo = 0, n_fim = 0;
    iniciar_sweep();
    for (int k = 1; k <= 100; k++) begin
      ciclo();
      obs   = {db_estado, direcao, largura, passo, fim_ciclo};
      exp_v = esperado(k);
      n_passo += int'(passo);
      n_fim   += int'(fim_ciclo);
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL sweep k=%0d: got {db,dir,lar,passo,fim}=%b required %b", k, obs, exp_v);
      end
    end
    n_cmp++;
    if (n_passo != 19) begin
      n_err++;
      $display("FAIL sweep_passo_count: got %0d required 19", n_passo);
    end
    n_cmp++;
    if (n_fim != 1) begin
      n_err++;
      $display("FAIL sweep_fim_count: got %0d required 1", n_fim);
    end
  endtask

  task automatic test_pause();
    iniciar_sweep();
    repeat (19) ciclo();   // k=19: code 011, timer at 2
    n_cmp++;
    if (largura !== 3'b011 || db_estado !== 4'd2) begin
      n_err++;
      $display("FAIL pause_setup: got lar=%b db=%0d required lar=011 db=2", largura, db_estado);
    end
    pausar = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ciclo();
      n_cmp++;
      if (largura !== 3'b011 || db_estado !== 4'd4 || passo !== 1'b0) begin
        n_err++;
        $display("FAIL pause_hold i=%0d: got lar=%b db=%0d passo=%b required lar=011 db=4 passo=0", i, largura, db_estado, passo);
      end
    end
    pausar = 1'b0;
    ciclo(); ciclo();
    n_cmp++;
    if (largura !== 3'b011 || db_estado !== 4'd2) begin
      n_err++;
      $display("FAIL pause_resume: got lar=%b db=%0d required lar=011 db=2", largura, db_estado);
    end
    ciclo();
    n_cmp++;
    if (largura !== 3'b011 || db_estado !== 4'd3) begin
      n_err++;
      $display("FAIL pause_avanca: got lar=%b db=%0d required lar=011 db=3", largura, db_estado);
    end
    ciclo();
    n_cmp++;
    if (largura !== 3'b100 || passo !== 1'b1) begin
      n_err++;
      $display("FAIL pause_step: got lar=%b passo=%b required lar=100 passo=1", largura, passo);
    end
  endtask

  task automatic test_stop();
    iniciar_sweep();
    repeat (47) ciclo();   // k=47: code 101 descending
    n_cmp++;
    if (largura !== 3'b101 || direcao !== 1'b1) begin
      n_err++;
      $display("FAIL stop_setup: got lar=%b dir=%b required lar=101 dir=1", largura, direcao);
    end
    ligar = 1'b0;
    ciclo();
    n_cmp++;
    if ({db_estado, direcao, largura, passo} !== 9'd0) begin
      n_err++;
      $display("FAIL stop_abort: got {db,dir,lar,passo}=%b required 0", {db_estado, direcao, largura, passo});
    end
    ligar = 1'b1;
    repeat (6) ciclo();
    n_cmp++;
    if (largura !== 3'b000 || db_estado !== 4'd3) begin
      n_err++;
      $display("FAIL restart_pre: got lar=%b db=%0d required lar=000 db=3", largura, db_estado);
    end
    ciclo();
    n_cmp++;
    if (largura !== 3'b001 || direcao !== 1'b0 || passo !== 1'b1) begin
      n_err++;
      $display("FAIL restart_step: got lar=%b dir=%b passo=%b required lar=001 dir=0 passo=1", largura, direcao, passo);
    end
  endtask

  task automatic test_manual();
    ligar = 1'b0; pausar = 1'b0; modo_manual = 1'b0;
    ciclo(); ciclo();
    modo_manual = 1'b1; posicao_manual = 3'b110;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd5 || largura !== 3'b000) begin
      n_err++;
      $display("FAIL manual_enter: got db=%0d lar=%b required db=5 lar=000", db_estado, largura);
    end
    ciclo();
    n_cmp++;
    if (largura !== 3'b110 || passo !== 1'b0 || fim_ciclo !== 1'b0) begin
      n_err++;
      $display("FAIL manual_110: got lar=%b passo=%b fim=%b required lar=110 passo=0 fim=0", largura, passo, fim_ciclo);
    end
    posicao_manual = 3'b010;
    ciclo();
    n_cmp++;
    if (largura !== 3'b010) begin
      n_err++;
      $display("FAIL manual_010: got lar=%b required 010", largura);
    end
    ligar = 1'b1;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd1 || largura !== 3'b000) begin
      n_err++;
      $display("FAIL manual_to_prepara: got db=%0d lar=%b required db=1 lar=000", db_estado, largura);
    end
    modo_manual = 1'b0;
  endtask

  task automatic test_simultaneous();
    iniciar_sweep();
    repeat (5) ciclo();    // k=5: ESPERA at terminal count
    ligar = 1'b0;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd0 || passo !== 1'b0 || largura !== 3'b000) begin
      n_err++;
      $display("FAIL stop_at_expiry: got db=%0d passo=%b lar=%b required db=0 passo=0 lar=000", db_estado, passo, largura);
    end
    ciclo();
    n_cmp++;
    if (passo !== 1'b0) begin
      n_err++;
      $display("FAIL stop_at_expiry_passo: got %b required 0", passo);
    end
    iniciar_sweep();
    repeat (5) ciclo();
    pausar = 1'b1;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd4 || passo !== 1'b0 || largura !== 3'b000) begin
      n_err++;
      $display("FAIL pause_at_expiry: got db=%0d passo=%b lar=%b required db=4 passo=0 lar=000", db_estado, passo, largura);
    end
    ciclo();
    pausar = 1'b0;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd2) begin
      n_err++;
      $display("FAIL pause_expiry_resume: got db=%0d required 2", db_estado);
    end
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd3 || largura !== 3'b000) begin
      n_err++;
      $display("FAIL pause_expiry_avanca: got db=%0d lar=%b required db=3 lar=000", db_estado, largura);
    end
    ciclo();
    n_cmp++;
    if (largura !== 3'b001 || passo !== 1'b1) begin
      n_err++;
      $display("FAIL pause_expiry_step: got lar=%b passo=%b required lar=001 passo=1", largura, passo);
    end
  endtask

  task automatic test_async_reset();
    iniciar_sweep();
    repeat (17) ciclo();   // k=17: code 011 just taken
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({db_estado, direcao, largura, passo, fim_ciclo} !== 10'd0) begin
      n_err++;
      $display("FAIL async_reset: got %b required %b", {db_estado, direcao, largura, passo, fim_ciclo}, 10'd0);
    end
    ciclo();
    ligar = 1'b0;
    reset = 1'b1;
    ciclo();
    n_cmp++;
    if (db_estado !== 4'd0 || largura !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset_release: got db=%0d lar=%b required db=0 lar=000", db_estado, largura);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_pause();
    test_stop();
    test_manual();
    test_simultaneous();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
